// File: rtl/wbc_arbiter.sv
// Round-robin arbiter for the shared control WISHBONE bus.
// Four masters (0 pcic, 1 turfc, 2 hkmc, 3 wbvio) compete for the bus. The
// arbiter grants one owner per cyc tenure, with no preemption. A per-transfer
// watchdog ends a stalled strobe with a one-cycle forced error, so a missing
// slave ack cannot lock the bus.
module wbc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMO_WIDTH      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] cyc_i,
  input  logic [3:0] stb_i,
  input  logic [3:0] master_en_i,
  input  logic       ack_i,
  input  logic       err_i,
  input  logic       rty_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_valid_o,
  output logic       force_err_o,
  output logic       stb_block_o,
  output logic       timeout_o,
  output logic [7:0] timeout_count_o
);

  typedef enum logic [1:0] {StIdle, StOwn, StTmo} state_e;

  // Last counter value before a stalled strobe times out.
  localparam logic [TMO_WIDTH-1:0] TmoLimit = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_WIDTH-1:0] TmoMax   = '1;

  state_e               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           grant_idx_q, grant_idx_d;
  logic                 grant_valid_q;
  logic [TMO_WIDTH-1:0] wdog_q, wdog_d;
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_q;

  logic [3:0] req;
  logic [1:0] rr_cand;
  logic [1:0] rr_winner;
  logic       rr_found;
  logic       owner_cyc;
  logic       owner_stb;
  logic       term;

  // A disabled master can finish its tenure but cannot win a new one.
  assign req       = cyc_i & master_en_i;
  assign owner_cyc = cyc_i[grant_idx_q];
  assign owner_stb = stb_i[grant_idx_q];
  assign term      = ack_i | err_i | rty_i;

  // Round-robin search: first request strictly after the last owner, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = grant_idx_q;
    rr_cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      rr_cand = grant_idx_q + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Next-state logic for ownership, watchdog and expiry counter.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    wdog_d      = wdog_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (rr_found) begin
          state_d     = StOwn;
          grant_d     = 4'b0001 << rr_winner;
          grant_idx_d = rr_winner;
        end
      end

      StOwn: begin
        if (!owner_cyc) begin
          // grant_idx is kept; it is the round-robin pointer for the next search.
          state_d = StIdle;
          grant_d = '0;
          wdog_d  = '0;
        end else if (!owner_stb || term) begin
          wdog_d = '0;
        end else if (wdog_q == TmoLimit) begin
          // A termination in this same cycle would have taken the branch above.
          state_d   = StTmo;
          wdog_d    = '0;
          tmo_cnt_d = (tmo_cnt_q == 8'hff) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
        end else begin
          wdog_d = (wdog_q == TmoMax) ? wdog_q : wdog_q + TMO_WIDTH'(1);
        end
      end

      StTmo: begin
        // Any late ack in this cycle is ignored; the owner only sees the error.
        wdog_d = '0;
        if (owner_cyc) begin
          state_d = StOwn;
        end else begin
          state_d = StIdle;
          grant_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  // State and output registers; outputs are flops so no input reaches them combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_idx_q   <= 2'd3;
      grant_valid_q <= 1'b0;
      wdog_q        <= '0;
      tmo_cnt_q     <= '0;
      tmo_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= |grant_d;
      wdog_q        <= wdog_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tmo_q         <= (state_d == StTmo);
    end
  end

  assign grant_o         = grant_q;
  assign grant_idx_o     = grant_idx_q;
  assign grant_valid_o   = grant_valid_q;
  assign force_err_o     = tmo_q;
  assign stb_block_o     = tmo_q;
  assign timeout_o       = tmo_q;
  assign timeout_count_o = tmo_cnt_q;

endmodule
